// File: rtl/spi_reg_write_master_if.sv
// ---------------------------------------------------------------------------
// spi_reg_write_master_if
//
// Bundles the requester handshake and the SPI pin signals of
// spi_reg_write_master so the controller and its surroundings share a
// single connection point.
//
// Signals
//   req_a/addr_a/data_a  requester A: level request, 7-bit address, 8-bit data
//   ack_a                1-cycle pulse: A's request accepted
//   req_b/addr_b/data_b  requester B: same rules as A
//   ack_b                1-cycle pulse: B's request accepted
//   busy                 controller is between grant and the end of the cs gap
//   err_addr             1-cycle pulse alongside ack_x for an out-of-range address
//   cs_n/sclk/copi       SPI mode-0 pins towards the peripheral
//
// Modports
//   master  the controller (consumes requests, drives acks and SPI pins)
//   slave   the system side (drives requests, observes acks and SPI pins)
// ---------------------------------------------------------------------------
interface spi_reg_write_master_if;
  logic       req_a;
  logic [6:0] addr_a;
  logic [7:0] data_a;
  logic       ack_a;

  logic       req_b;
  logic [6:0] addr_b;
  logic [7:0] data_b;
  logic       ack_b;

  logic       busy;
  logic       err_addr;

  logic       cs_n;
  logic       sclk;
  logic       copi;

  modport master (
    input  req_a, addr_a, data_a,
    input  req_b, addr_b, data_b,
    output ack_a, ack_b, busy, err_addr,
    output cs_n, sclk, copi
  );

  modport slave (
    output req_a, addr_a, data_a,
    output req_b, addr_b, data_b,
    input  ack_a, ack_b, busy, err_addr,
    input  cs_n, sclk, copi
  );
endinterface

// File: rtl/spi_reg_write_master.sv
// ---------------------------------------------------------------------------
// spi_reg_write_master
//
// Writes the control registers of an SPI peripheral on behalf of two on-chip
// requesters (A and B) that share one SPI link through a round-robin arbiter.
// Each accepted request becomes one 16-bit write frame
//   {1'b1, addr[6:0], data[7:0]}
// sent MSB first in SPI mode 0 (sclk idles low, copi changes on the falling
// edge, the peripheral samples on the rising edge).
//
// Parameters
//   CLK_DIV   clk cycles per sclk half-period; must be >= 4 so the
//             peripheral's 2-FF copi synchronizer settles before each rise
//   NUM_REGS  number of valid register addresses (addr >= NUM_REGS rejected);
//             must fit in the 7-bit address
//   CS_GAP    clk cycles spent in the GAP state (cs_n high, busy high) after
//             each frame; must be >= 1
//
// Ports
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    spi_reg_write_master_if.master: requester handshakes, busy,
//          err_addr and the cs_n/sclk/copi pins
//
// Timing
//   Every output is a flop whose next value is decoded from the current state,
//   so the pins trail the FSM by exactly one cycle:
//     req seen in IDLE -> GRANT -> ack one cycle later -> cs_n falls next cycle.
//   cs_n is low for 33*CLK_DIV cycles per frame (SETUP, 16 high and 15 low
//   phases, TAIL) with exactly 16 sclk rising edges. Between back-to-back
//   frames cs_n stays high for the CS_GAP cycles of GAP plus the IDLE and
//   GRANT cycles that arbitrate the next request.
// ---------------------------------------------------------------------------
module spi_reg_write_master #(
  parameter int CLK_DIV  = 4,
  parameter int NUM_REGS = 5,
  parameter int CS_GAP   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  spi_reg_write_master_if.master        bus
);

  // FSM encoding kept as plain constants for compatibility with older flows.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GRANT = 3'd1;
  localparam logic [2:0] S_SETUP = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_TAIL  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  // Round-robin pointer: which requester wins when both are active.
  localparam logic RR_A = 1'b0;
  localparam logic RR_B = 1'b1;

  // One shared cycle counter times SETUP, each sclk half-period, TAIL and GAP.
  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP - 1);
  localparam logic [6:0]       ADDR_LIMIT = 7'(NUM_REGS);
  localparam logic [3:0]       LAST_BIT   = 4'd15;

  // FSM and datapath state
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [3:0]       bit_q,   bit_d;     // index of the bit currently on copi
  logic             phase_q, phase_d;   // sclk level inside SHIFT (1 = high)
  logic [15:0]      frame_q, frame_d;   // frame_q[15] is always the bit on copi
  logic             rr_q,    rr_d;

  // Registered outputs
  logic ack_a_q, ack_a_d;
  logic ack_b_q, ack_b_d;
  logic err_q,   err_d;
  logic busy_q,  busy_d;
  logic cs_n_q,  cs_n_d;
  logic sclk_q,  sclk_d;
  logic copi_q,  copi_d;

  // Arbitration
  logic       any_req;
  logic       win_b;
  logic [6:0] sel_addr;
  logic [7:0] sel_data;
  logic       addr_bad;

  assign any_req  = bus.req_a | bus.req_b;
  assign win_b    = bus.req_b & (~bus.req_a | (rr_q == RR_B));
  assign sel_addr = win_b ? bus.addr_b : bus.addr_a;
  assign sel_data = win_b ? bus.data_b : bus.data_a;
  assign addr_bad = (sel_addr >= ADDR_LIMIT);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    frame_d = frame_q;
    rr_d    = rr_q;
    ack_a_d = 1'b0;
    ack_b_d = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_GRANT;
        end
      end

      S_GRANT: begin
        cnt_d = '0;
        if (!any_req) begin
          // Request withdrawn before its ack: drop it silently.
          state_d = S_IDLE;
        end else begin
          ack_a_d = ~win_b;
          ack_b_d = win_b;
          rr_d    = win_b ? RR_A : RR_B;
          frame_d = {1'b1, sel_addr, sel_data};
          if (addr_bad) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_SETUP;
          end
        end
      end

      S_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          phase_d = 1'b1;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (phase_q) begin
            // End of a high phase is the falling edge: advance copi here so
            // it is stable for the whole next rise.
            if (bit_q == LAST_BIT) begin
              state_d = S_TAIL;
            end else begin
              phase_d = 1'b0;
              bit_d   = bit_q + 4'd1;
              frame_d = {frame_q[14:0], 1'b0};
            end
          end else begin
            phase_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_TAIL: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decode: pin values follow the current state, registered below.
  // -------------------------------------------------------------------------
  always_comb begin
    cs_n_d = 1'b1;
    sclk_d = 1'b0;
    copi_d = 1'b0;
    busy_d = (state_q != S_IDLE);

    unique case (state_q)
      S_SETUP: begin
        cs_n_d = 1'b0;
        copi_d = frame_q[15];
      end
      S_SHIFT: begin
        cs_n_d = 1'b0;
        sclk_d = phase_q;
        copi_d = frame_q[15];
      end
      S_TAIL: begin
        cs_n_d = 1'b0;
      end
      default: begin
        cs_n_d = 1'b1;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      frame_q <= '0;
      rr_q    <= RR_A;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      frame_q <= frame_d;
      rr_q    <= rr_d;
      ack_a_q <= ack_a_d;
      ack_b_q <= ack_b_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      copi_q  <= copi_d;
    end
  end

  assign bus.ack_a    = ack_a_q;
  assign bus.ack_b    = ack_b_q;
  assign bus.err_addr = err_q;
  assign bus.busy     = busy_q;
  assign bus.cs_n     = cs_n_q;
  assign bus.sclk     = sclk_q;
  assign bus.copi     = copi_q;

endmodule
